rr_mux_arb: RTL

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/rr_mux_arb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel arbitrating multiplexer with a single registered
// output stage.
//
// Each cycle one input channel may be granted, chosen either by a rotating
// round-robin search (MODE=0) or by an explicit channel index (MODE=1).
// The granted beat is captured into the output register whenever that
// register is empty or being drained in the same cycle, so a continuously
// ready downstream sees one beat per cycle.
//
// Parameters
//   WIDTH     data bits per channel
//   CHANNELS  number of input channels (2..16)
//   SELW      channel-index width, max(1, ceil(log2(CHANNELS))) (derived)
//
// Ports
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   IN_DATA    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   IN_VALID   per-channel valid
//   IN_READY   per-channel ready (combinational, one-hot or zero)
//   MODE       0 = round-robin, 1 = fixed select
//   SEL        channel index used when MODE=1
//   OUT_DATA   registered selected data
//   OUT_CHAN   registered index of the channel that supplied OUT_DATA
//   OUT_VALID  output register holds a beat
//   OUT_READY  downstream accepts the beat this cycle
module rr_mux_arb #(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned SELW     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [CHANNELS*WIDTH-1:0]  IN_DATA,
  input  logic [CHANNELS-1:0]        IN_VALID,
  output logic [CHANNELS-1:0]        IN_READY,
  input  logic                       MODE,
  input  logic [SELW-1:0]            SEL,
  output logic [WIDTH-1:0]           OUT_DATA,
  output logic [SELW-1:0]            OUT_CHAN,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY
);

  // Round-robin pointer: channel searched first on the next arbitration.
  logic [SELW-1:0]  ptr_q;

  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic             space;
  logic             acc;
  logic [SELW-1:0]  ptr_nxt;
  logic [WIDTH-1:0] grant_data;

  // Output register can take a new beat when empty or draining this cycle.
  assign space = !OUT_VALID || OUT_READY;
  assign acc   = grant_vld && space;

  // Grant selection. In round-robin mode the search visits PTR, PTR+1, ...
  // wrapping modulo CHANNELS; the first valid channel wins. PTR is always
  // below CHANNELS, so a single conditional subtraction is enough to wrap.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (MODE) begin
      if ((32'(SEL) < CHANNELS) && IN_VALID[SEL]) begin
        grant_vld = 1'b1;
        grant_idx = SEL;
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= CHANNELS) begin
          idx = idx - CHANNELS;
        end
        if (!grant_vld && IN_VALID[idx[SELW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = idx[SELW-1:0];
        end
      end
    end
  end

  // Ready goes only to the granted channel, and only when the beat will be
  // captured; this keeps IN_READY one-hot or zero.
  always_comb begin
    IN_READY = '0;
    if (acc) begin
      IN_READY[grant_idx] = 1'b1;
    end
  end

  assign grant_data = IN_DATA[grant_idx*WIDTH +: WIDTH];

  // Pointer advances past the granted channel in either mode.
  always_comb begin
    if (32'(grant_idx) == CHANNELS - 1) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = grant_idx + 1'b1;
    end
  end

  // Output stage and pointer. A drain with no new grant clears only the
  // valid flag; data and channel index hold their last values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_CHAN  <= '0;
      ptr_q     <= '0;
    end else if (acc) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= grant_data;
      OUT_CHAN  <= grant_idx;
      ptr_q     <= ptr_nxt;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule
